csa_operand_accumulator: RTL and testbench
==========================================

CSA_OPERAND_ACCUMULATOR -- requirements
Module: csa_operand_accumulator

Interface
REQ-001 Parameter N, default 64, is the operand and result width; it matches the width of the downstream N-bit Ling adder.
REQ-002 Parameter CNT_W, default 8, is the operand-counter width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid operand.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  N  operand.
REQ-008 in_last  input  1  the operand is the final one of the packet; qualified by in_valid.
REQ-009 out_valid  output  1  out_a/out_b/out_cin hold a packet result.
REQ-010 out_ready  input  1  the downstream adder stage consumes the result.
REQ-011 out_a  output  N  redundant sum vector, fed to adder input a.
REQ-012 out_b  output  N  redundant carry vector, pre-shifted, fed to adder input b.
REQ-013 out_cin  output  1  adder carry-in; constant 0.

Function
REQ-014 Operand acceptance: in_valid && in_ready at a rising edge.
REQ-015 Result handshake: out_valid && out_ready at a rising edge.
REQ-016 FSM has three states: IDLE, ACC, OUT.
- IDLE: S=0, C=0, in_ready=1.
- ACC: in_ready=1.
- OUT: in_ready=0, out_valid=1.
REQ-017 Transitions:
- IDLE/ACC, accept with in_last=0 -> ACC.
- IDLE/ACC, accept with in_last=1 -> OUT.
- OUT, result handshake -> IDLE, with S and C cleared.
- All other cases hold the current state.
REQ-018 On each accept, the 3:2 compression with operand d is:
- S' = S ^ C ^ d
- M = (S&C) | (S&d) | (C&d)
- C' = {M[N-2:0], 1'b0}
- M[N-1] is discarded (mod 2^N).
REQ-019 Output mapping and result rule:
- out_a = S and out_b = C in every state.
- Outputs are meaningful only while out_valid = 1.
- (out_a + out_b) mod 2^N equals the sum of all packet operands mod 2^N.
REQ-020 Latency: out_valid rises in the cycle after the in_last operand is accepted.
REQ-021 For a one-operand packet with operand d, the result is out_a = d, out_b = 0.
REQ-022 While out_valid=1 and out_ready=0, out_a, out_b and out_valid hold stable.
REQ-023 No operand is accepted in OUT; the block processes one packet at a time.
REQ-024 out_ready is ignored outside OUT.
REQ-025 in_last, in_data and in_valid are ignored while in_ready = 0.

Reset
REQ-026 Reset values of all state and outputs:
- state = IDLE; S = 0; C = 0.
- in_ready = 1 in the cycle after reset deassertion.
- out_valid = 0, out_a = 0, out_b = 0, out_cin = 0.
REQ-027 Reset asserted mid-packet (ACC) or mid-handshake (OUT) discards the partial or pending result with no output handshake.
REQ-028 Reset has priority over a simultaneous accept or result handshake.

Configuration
REQ-029 Macro CSA_ACC_COUNT_EN controls an operand counter.
- When defined, the block adds output out_count (width CNT_W).
- out_count is the number of operands accepted in the current packet, saturating at 2^CNT_W-1.
- out_count is cleared by reset and by the result handshake.
- out_count is valid with out_valid.
- When undefined, the port and counter are absent; all other behaviour is unchanged.

Structure
REQ-030 Shared package csa_acc_pkg holds:
- the state encodings (IDLE=2'd0, ACC=2'd1, OUT=2'd2);
- the default values of N and CNT_W.
REQ-031 The bitwise full-adder row is a separate combinational sub-module, csa_3to2 (N-bit inputs x, y, z; outputs s and maj). It is instantiated once.

Verification
REQ-032 The bench runs at N=8 and covers these directed scenarios:
- Single operand 0x5A with in_last=1 -> next cycle: out_valid=1, out_a=0x5A, out_b=0x00, out_cin=0.
- Operands 0xFF, 0x01, 0x01 (last) -> (out_a + out_b) mod 256 = 0x01; an 8-bit Ling adder on out_a/out_b gives s=0x01.
- Operands 0x10, 0x20, 0x30, 0x40 (last), out_ready held 0 for 3 cycles -> out_a, out_b, out_valid stable; in_ready=0 throughout; sum = 0xA0; IDLE after the handshake.
- Reset pulsed after two operands of a packet -> out_valid stays 0; the next packet 0x07 (last) gives out_a=0x07, out_b=0.
- With CSA_ACC_COUNT_EN: 5 operands -> out_count=5. With CNT_W=2 and 5 operands -> out_count=3 (saturated).
- Back-to-back packets with in_valid held 1 -> the operand presented during OUT is not accepted; it is accepted in IDLE immediately after the handshake.

Source files
------------

// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save operand accumulator.
// Holds the FSM state encodings and the default operand/counter widths.
package csa_acc_pkg;

  localparam int unsigned N_DEF     = 64;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/csa_operand_accumulator_if.sv
// Handshake bundle between an operand source, the accumulator and the
// downstream adder stage.
//   in_valid/in_ready/in_data/in_last : operand stream into the accumulator
//   out_valid/out_ready               : result handshake
//   out_a/out_b/out_cin               : redundant result for the adder
//   out_count                         : operands in packet (CSA_ACC_COUNT_EN only)
// slave modport is the accumulator side, master modport the environment side.
interface csa_operand_accumulator_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic         out_cin;
`ifdef CSA_ACC_COUNT_EN
  logic [CNT_W-1:0] out_count;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cin
`ifdef CSA_ACC_COUNT_EN
    , output out_count
`endif
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cin
`ifdef CSA_ACC_COUNT_EN
    , input out_count
`endif
  );
endinterface

// File: rtl/csa_3to2.sv
// Bitwise full-adder row (3:2 compressor).
//   x, y, z : N-bit inputs
//   s       : bitwise sum  x ^ y ^ z
//   maj     : bitwise majority (unshifted carry)
module csa_3to2 #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] maj
);
  always_comb begin
    s   = x ^ y ^ z;
    maj = (x & y) | (x & z) | (y & z);
  end
endmodule

// File: rtl/csa_operand_accumulator.sv
// Accumulates a packet of N-bit operands in carry-save form (S, C) and
// presents the redundant pair to a downstream N-bit adder.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : csa_operand_accumulator_if.slave
//          (in_valid/in_ready/in_data/in_last, out_valid/out_ready,
//           out_a = S, out_b = C, out_cin = 0)
// Optional macro CSA_ACC_COUNT_EN adds bus.out_count, the saturating
// number of operands accepted in the current packet.
module csa_operand_accumulator
  import csa_acc_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  csa_operand_accumulator_if.slave  bus
);

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_s;
  logic [N-1:0] r_c;
  logic [N-1:0] w_s;
  logic [N-1:0] w_maj;
  logic [N-1:0] w_c;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_done;

  csa_3to2 #(.N(N)) u_csa (
    .x   (r_s),
    .y   (r_c),
    .z   (bus.in_data),
    .s   (w_s),
    .maj (w_maj)
  );

  // Carry weight doubles; the top majority bit falls off (mod 2^N).
  assign w_c = w_maj << 1;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_done   = w_out_valid && bus.out_ready;

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE, ACC: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = bus.in_last ? OUT : ACC;
        end
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_s <= w_s;
        r_c <= w_c;
      end else if (w_done) begin
        r_s <= '0;
        r_c <= '0;
      end
    end
  end

`ifdef CSA_ACC_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (r_count != '1) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_done) begin
      r_count <= '0;
    end
  end

  assign bus.out_count = r_count;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_a     = r_s;
  assign bus.out_b     = r_c;
  assign bus.out_cin   = 1'b0;

endmodule

// File: tb/tb_csa_operand_accumulator.sv
module tb_csa_operand_accumulator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa_operand_accumulator_if #(.N(8), .CNT_W(8)) bus ();

  csa_operand_accumulator #(.N(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CSA_ACC_COUNT_EN
  // Narrow-counter copy driven by the same stimulus to observe saturation.
  csa_operand_accumulator_if #(.N(8), .CNT_W(2)) bus2 ();
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  csa_operand_accumulator #(.N(8), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );
`endif

  typedef struct {
    logic [7:0] sum;
    bit         chk_ab;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic expect_pkt(input logic [7:0] sum, input bit chk_ab, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] cnt, input logic [1:0] cnt2);
    exp_t e;
    e.sum = sum; e.chk_ab = chk_ab; e.a = a; e.b = b; e.cnt = cnt; e.cnt2 = cnt2;
    sb.push_back(e);
  endtask

  // Monitor: compares every presented result handshake against the queue.
  exp_t       m_e;
  logic [7:0] m_sum;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=a:0x%0h b:0x%0h required=none", bus.out_a, bus.out_b);
      end else begin
        m_e   = sb.pop_front();
        m_sum = bus.out_a + bus.out_b;
        chk("result_sum", {24'd0, m_sum}, {24'd0, m_e.sum});
        if (m_e.chk_ab) begin
          chk("result_a", {24'd0, bus.out_a}, {24'd0, m_e.a});
          chk("result_b", {24'd0, bus.out_b}, {24'd0, m_e.b});
        end
        chk("result_cin", {31'd0, bus.out_cin}, 32'd0);
`ifdef CSA_ACC_COUNT_EN
        chk("result_count", {24'd0, bus.out_count}, {24'd0, m_e.cnt});
        chk("result_count_sat", {30'd0, bus2.out_count}, {30'd0, m_e.cnt2});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready:0 required=in_ready:1");
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_a", {24'd0, bus.out_a}, 32'd0);
    chk("rst_out_b", {24'd0, bus.out_b}, 32'd0);
    chk("rst_out_cin", {31'd0, bus.out_cin}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single operand, one-cycle latency.
    expect_pkt(8'h5A, 1'b1, 8'h5A, 8'h00, 8'd1, 2'd1);
    send(8'h5A, 1'b1);
    chk("single_latency_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_latency_a", {24'd0, bus.out_a}, 32'h5A);
    drain();

    // Wraparound: FF + 01 + 01 = 0x101 -> 0x01; S=FD, C=04.
    expect_pkt(8'h01, 1'b1, 8'hFD, 8'h04, 8'd3, 2'd3);
    send(8'hFF, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    drain();

    // Back-pressure: result held for 3 cycles; S=20, C=80, sum A0.
    bus.out_ready = 1'b0;
    expect_pkt(8'hA0, 1'b1, 8'h20, 8'h80, 8'd4, 2'd3);
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_a", {24'd0, bus.out_a}, 32'h20);
      chk("stall_b", {24'd0, bus.out_b}, 32'h80);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("post_hs_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_hs_a", {24'd0, bus.out_a}, 32'd0);
    chk("post_hs_b", {24'd0, bus.out_b}, 32'd0);
    drain();

    // Reset mid-packet discards the partial sum.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_a", {24'd0, bus.out_a}, 32'd0);
    chk("midrst_b", {24'd0, bus.out_b}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      step();
    end
    expect_pkt(8'h07, 1'b1, 8'h07, 8'h00, 8'd1, 2'd1);
    send(8'h07, 1'b1);
    drain();

    // Five operands: 1+2+3+4+5 = 0x0F.
    expect_pkt(8'h0F, 1'b0, 8'h00, 8'h00, 8'd5, 2'd3);
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), (i == 5) ? 1'b1 : 1'b0);
    end
    drain();

    // Back-to-back with in_valid held: operand shown during OUT waits.
    bus.out_ready = 1'b0;
    expect_pkt(8'h03, 1'b1, 8'h03, 8'h00, 8'd1, 2'd1);
    expect_pkt(8'h04, 1'b1, 8'h04, 8'h00, 8'd1, 2'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    bus.in_last  = 1'b1;
    step();
    chk("b2b_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_first_a", {24'd0, bus.out_a}, 32'h03);
    bus.in_data = 8'h04;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("b2b_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("b2b_hold_a", {24'd0, bus.out_a}, 32'h03);
    end
    bus.out_ready = 1'b1;
    step();
    chk("b2b_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_second_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_second_a", {24'd0, bus.out_a}, 32'h04);
    drain();

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
